// File: rtl/hir_mem_pkg.sv
// Shared types and default widths for the HIR kernel memory responder.
package hir_mem_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/hir_mem_responder_if.sv
// Host stream and kernel memory-port bundle; slave = responder, master = host/kernel side.
interface hir_mem_responder_if
    import hir_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              tstart;
    logic [ADDR_W-1:0] v0_addr;
    logic              v0_rd_en;
    logic [DATA_W-1:0] v0_rd_data;
    logic [ADDR_W-1:0] v1_addr;
    logic              v1_wr_en;
    logic [DATA_W-1:0] v1_wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              done;
    logic              err;

    modport slave (
        input  in_valid, in_data, v0_addr, v0_rd_en, v1_addr, v1_wr_en, v1_wr_data, out_ready,
        output in_ready, tstart, v0_rd_data, out_valid, out_data, done, err
    );

    modport master (
        output in_valid, in_data, v0_addr, v0_rd_en, v1_addr, v1_wr_en, v1_wr_data, out_ready,
        input  in_ready, tstart, v0_rd_data, out_valid, out_data, done, err
    );
endinterface

// File: rtl/hir_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module hir_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // Array is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb rdata_d = re ? mem[raddr] : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/hir_mem_responder.sv
// Memory-side wrapper for an HIR kernel: preload input memory, pulse tstart,
// serve kernel reads/writes, then drain the output memory to the host.
module hir_mem_responder
    import hir_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int IN_WORDS  = 256,
    parameter int OUT_WORDS = 256
) (
    input logic clk,
    input logic rst_n,
    hir_mem_responder_if.slave bus
);
    localparam logic [ADDR_W-1:0] IN_LAST  = ADDR_W'(IN_WORDS - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_WORDS - 1);
    localparam logic [ADDR_W:0]   IN_LIM   = (ADDR_W+1)'(IN_WORDS);
    localparam logic [ADDR_W:0]   OUT_LIM  = (ADDR_W+1)'(OUT_WORDS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] drn_cnt_q, drn_cnt_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              pf_vld_q, pf_vld_d;
    logic              in_ready_q, in_ready_d;
    logic              tstart_q, tstart_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              in_fire, rd_ok, wr_ok, out_fire, load_out, drn_re;
    logic [DATA_W-1:0] drn_rdata;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        pf_vld_d    = pf_vld_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        in_fire  = bus.in_valid & in_ready_q;
        rd_ok    = bus.v0_rd_en & (state_q == RUN);
        wr_ok    = bus.v1_wr_en & (state_q == RUN);
        out_fire = out_valid_q & bus.out_ready;
        // Prefetch slot (RAM read register) drains into the output register whenever it frees up.
        load_out = pf_vld_q & (~out_valid_q | out_fire);
        drn_re   = (state_q == DRAIN) & (rd_ptr_q < OUT_LIM) & (~pf_vld_q | load_out);

        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == IN_LAST) state_d = START;
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (wr_ok) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == OUT_LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drn_re) rd_ptr_d = rd_ptr_q + 1'b1;
                pf_vld_d    = drn_re | (pf_vld_q & ~load_out);
                out_valid_d = load_out | (out_valid_q & ~out_fire);
                if (load_out) out_data_d = drn_rdata;
                if (out_fire) begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                    if (drn_cnt_q == OUT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                state_d    = LOAD;
                load_cnt_d = '0;
                wr_cnt_d   = '0;
                drn_cnt_d  = '0;
                rd_ptr_d   = '0;
                pf_vld_d   = 1'b0;
            end
            default: state_d = LOAD;
        endcase

        in_ready_d = (state_d == LOAD);
        tstart_d   = (state_d == START);
        done_d     = (state_d == DONE);
        err_d      = err_q
                   | ((bus.v0_rd_en | bus.v1_wr_en) & (state_q != RUN))
                   | (rd_ok & ({1'b0, bus.v0_addr} >= IN_LIM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            wr_cnt_q    <= '0;
            drn_cnt_q   <= '0;
            rd_ptr_q    <= '0;
            pf_vld_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            tstart_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            pf_vld_q    <= pf_vld_d;
            in_ready_q  <= in_ready_d;
            tstart_q    <= tstart_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    hir_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_in_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (in_fire),
        .waddr (load_cnt_q),
        .wdata (bus.in_data),
        .re    (rd_ok),
        .raddr (bus.v0_addr),
        .rdata (bus.v0_rd_data)
    );

    hir_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (bus.v1_addr),
        .wdata (bus.v1_wr_data),
        .re    (drn_re),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (drn_rdata)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.tstart    = tstart_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_hir_mem_responder.sv
// Directed bench for hir_mem_responder with IN_WORDS = OUT_WORDS = 4.
module tb_hir_mem_responder;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NW = 4;

    typedef struct {
        logic [NW-1:0][DW-1:0] ld;
        logic [NW-1:0][AW-1:0] wa;
        logic [NW-1:0][DW-1:0] wd;
        logic [NW-1:0][DW-1:0] ex;
        logic [7:0]            pat;
        int                    plen;
    } job_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    job_t jobs [5];
    rd_t  rd_tab [NW];

    always #5 clk = ~clk;

    hir_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    hir_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .IN_WORDS(NW), .OUT_WORDS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_words(input logic [NW-1:0][DW-1:0] w);
        int wt;
        for (int i = 0; i < NW; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            wt = 0;
            while (!bus.in_ready && wt < 20) begin
                tick();
                wt++;
            end
            if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("tstart_after_load", 32'(bus.tstart), 32'd1);
        chk("in_ready_in_start", 32'(bus.in_ready), 32'd0);
        tick();
        chk("tstart_one_cycle", 32'(bus.tstart), 32'd0);
    endtask

    task automatic write_words(input logic [NW-1:0][AW-1:0] wa, input logic [NW-1:0][DW-1:0] wd, input int n);
        for (int i = 0; i < n; i++) begin
            bus.v1_wr_en   = 1'b1;
            bus.v1_addr    = wa[i];
            bus.v1_wr_data = wd[i];
            tick();
        end
        bus.v1_wr_en = 1'b0;
    endtask

    task automatic drain(input logic [NW-1:0][DW-1:0] ex, input logic [7:0] pat, input int plen);
        logic [DW-1:0] got [$];
        int            cyc = 0, first = -1, k = 0, last_hs = 0;
        logic          pv = 1'b0, pr = 1'b0;
        logic [DW-1:0] pd = '0;
        while (got.size() < NW && cyc < 40) begin
            if (pv && !pr) begin
                chk("stall_valid_hold", 32'(bus.out_valid), 32'd1);
                chk("stall_data_hold", bus.out_data, pd);
            end
            if (bus.out_valid && first < 0) first = cyc;
            bus.out_ready = (first >= 0) ? pat[k % plen] : 1'b0;
            if (first >= 0) k++;
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                last_hs = cyc;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("first_valid_latency_ok", 32'(first >= 0 && first <= 2), 32'd1);
        chk("drain_count", 32'(got.size()), 32'(NW));
        for (int i = 0; i < NW && i < got.size(); i++) chk("drain_word", got[i], ex[i]);
        if (plen == 1) chk("drain_no_bubble", 32'(last_hs - first), 32'(NW - 1));
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("valid_low_in_done", 32'(bus.out_valid), 32'd0);
        tick();
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("in_ready_after_done", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic chk_reset_vals;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_tstart", 32'(bus.tstart), 32'd0);
        chk("rst_v0_rd_data", bus.v0_rd_data, 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;  bus.in_data = '0;
        bus.v0_addr = '0;     bus.v0_rd_en = 1'b0;
        bus.v1_addr = '0;     bus.v1_wr_en = 1'b0;  bus.v1_wr_data = '0;
        bus.out_ready = 1'b0;

        // job 0: basic; job 1: stalled drain; job 2: repeated address; job 3: aborted by reset; job 4: fresh job
        jobs[0].ld = {32'd13, 32'd12, 32'd11, 32'd10};
        jobs[0].wa = {8'd2, 8'd1, 8'd0, 8'd3};
        jobs[0].wd = {32'd6, 32'd5, 32'd4, 32'd7};
        jobs[0].ex = {32'd7, 32'd6, 32'd5, 32'd4};
        jobs[0].pat = 8'h01; jobs[0].plen = 1;
        jobs[1] = jobs[0];
        jobs[1].ld = {32'd23, 32'd22, 32'd21, 32'd20};
        jobs[1].pat = 8'h59; jobs[1].plen = 7;
        jobs[2].ld = {32'd33, 32'd32, 32'd31, 32'd30};
        jobs[2].wa = {8'd1, 8'd0, 8'd2, 8'd2};
        jobs[2].wd = {32'd41, 32'd40, 32'd8, 32'd9};
        jobs[2].ex = {32'd7, 32'd8, 32'd41, 32'd40};
        jobs[2].pat = 8'h01; jobs[2].plen = 1;
        jobs[3] = jobs[0];
        jobs[3].ld = {32'd53, 32'd52, 32'd51, 32'd50};
        jobs[3].wa = {8'd3, 8'd2, 8'd1, 8'd0};
        jobs[3].wd = {32'd4, 32'd3, 32'd2, 32'd1};
        jobs[4].ld = {32'd63, 32'd62, 32'd61, 32'd60};
        jobs[4].wa = {8'd3, 8'd2, 8'd1, 8'd0};
        jobs[4].wd = {32'd103, 32'd102, 32'd101, 32'd100};
        jobs[4].ex = {32'd103, 32'd102, 32'd101, 32'd100};
        jobs[4].pat = 8'h01; jobs[4].plen = 1;
        for (int i = 0; i < NW; i++) rd_tab[i] = '{AW'(i), DW'(10 + i)};

        tick(); tick();
        chk_reset_vals();
        rst_n = 1'b1;
        chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        tick();
        chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);

        // job 0: back-to-back reads, then hold
        load_words(jobs[0].ld);
        for (int i = 0; i < NW; i++) begin
            bus.v0_rd_en = 1'b1;
            bus.v0_addr  = rd_tab[i].addr;
            tick();
            chk("v0_read", bus.v0_rd_data, rd_tab[i].exp);
        end
        bus.v0_rd_en = 1'b0;
        bus.v0_addr  = 8'd0;
        tick();
        chk("v0_read_hold", bus.v0_rd_data, 32'd13);
        write_words(jobs[0].wa, jobs[0].wd, NW);
        drain(jobs[0].ex, jobs[0].pat, jobs[0].plen);

        // job 1
        load_words(jobs[1].ld);
        bus.v0_rd_en = 1'b1; bus.v0_addr = 8'd2;
        tick();
        bus.v0_rd_en = 1'b0;
        chk("v0_read_job1", bus.v0_rd_data, 32'd22);
        write_words(jobs[1].wa, jobs[1].wd, NW);
        drain(jobs[1].ex, jobs[1].pat, jobs[1].plen);
        chk("err_clean", 32'(bus.err), 32'd0);

        // job 2: stray write in LOAD must flag err and leave out_mem[3]=7
        bus.v1_wr_en = 1'b1; bus.v1_addr = 8'd3; bus.v1_wr_data = 32'hDEAD;
        tick();
        bus.v1_wr_en = 1'b0;
        chk("err_wr_in_load", 32'(bus.err), 32'd1);
        load_words(jobs[2].ld);
        write_words(jobs[2].wa, jobs[2].wd, NW);
        drain(jobs[2].ex, jobs[2].pat, jobs[2].plen);
        chk("err_sticky", 32'(bus.err), 32'd1);

        // job 3: abort by reset mid-RUN
        load_words(jobs[3].ld);
        bus.v0_rd_en = 1'b1; bus.v0_addr = 8'd1;
        tick();
        bus.v0_rd_en = 1'b0;
        chk("v0_read_job3", bus.v0_rd_data, 32'd51);
        write_words(jobs[3].wa, jobs[3].wd, 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("in_ready_after_abort", 32'(bus.in_ready), 32'd1);

        // job 4: out-of-range read flags err; job completes normally
        load_words(jobs[4].ld);
        bus.v0_rd_en = 1'b1; bus.v0_addr = 8'd5;
        tick();
        chk("err_addr_range", 32'(bus.err), 32'd1);
        bus.v0_addr = 8'd3;
        tick();
        bus.v0_rd_en = 1'b0;
        chk("v0_read_job4", bus.v0_rd_data, 32'd63);
        write_words(jobs[4].wa, jobs[4].wd, NW);
        drain(jobs[4].ex, jobs[4].pat, jobs[4].plen);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hir_mem_responder.md
Name: hir_mem_responder

Overview:
- Memory-side counterpart of an HIR-generated kernel such as `convolution`.
- Owns the kernel's input memory (v0 read port) and output memory (v1 write port), and responds to kernel reads with fixed latency.
- Sequences the kernel: host preload via stream, one-cycle `tstart` pulse, kernel run, host drain via stream.
- Replaces ad-hoc testbench memory models and is the synthesizable wrapper around a kernel in integration tests.

Parameters:
DATA_W, 32, word width of both memories and both host streams
ADDR_W, 8, kernel address width; each memory depth is 2**ADDR_W
IN_WORDS, 256, words preloaded per job (1..2**ADDR_W)
OUT_WORDS, 256, kernel writes that end a job (1..2**ADDR_W)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  host preload word valid
in_ready  out  1  preload accepted when in_valid & in_ready
in_data  in  DATA_W  preload word; stored at addresses 0,1,2,...
tstart  out  1  one-cycle kernel start pulse
v0_addr  in  ADDR_W  kernel read address
v0_rd_en  in  1  kernel read request
v0_rd_data  out  DATA_W  read response
v1_addr  in  ADDR_W  kernel write address
v1_wr_en  in  1  kernel write strobe
v1_wr_data  in  DATA_W  kernel write data
out_valid  out  1  drain word valid
out_ready  in  1  host drain ready
out_data  out  DATA_W  drained word, output-memory address order 0..OUT_WORDS-1
done  out  1  one-cycle pulse after the last drain handshake
err  out  1  sticky protocol-violation flag

Behaviour:
- States: LOAD, START, RUN, DRAIN, DONE. On reset the FSM enters LOAD.
- Reset values: in_ready=0, tstart=0, v0_rd_data=0, out_valid=0, out_data=0, done=0, err=0, all counters 0. Memory contents are not reset.
- Reset asserted mid-job aborts immediately to these values.
- LOAD:
  - in_ready=1 from the first cycle after reset release or after DONE.
  - Each handshake writes in_data to in_mem[load_cnt] and increments load_cnt.
  - On the handshake with load_cnt==IN_WORDS-1: go to START, in_ready=0 next cycle.
- START: tstart=1 for exactly this one cycle, then RUN.
- RUN, reads:
  - v0_rd_en high at edge N → v0_rd_data = in_mem[v0_addr] after edge N+1 (latency 1).
  - v0_rd_data holds its value while v0_rd_en is low.
  - Back-to-back reads every cycle are supported.
- RUN, writes:
  - v1_wr_en high → out_mem[v1_addr] <= v1_wr_data; wr_cnt increments on every strobe, including repeated addresses (last write wins).
  - When the strobe with wr_cnt==OUT_WORDS-1 lands: go to DRAIN.
  - Reads and writes in the same cycle are independent (separate memories).
- err set (sticky until reset):
  - v0_rd_en or v1_wr_en high in any state other than RUN; the access is ignored and the memory is unchanged.
  - v0_addr >= IN_WORDS during a read; data returned is in_mem[v0_addr] regardless.
- DRAIN:
  - Registered RAM read with one-word prefetch.
  - out_valid rises no later than 2 cycles after entering DRAIN.
  - out_data/out_valid stay stable while out_valid & !out_ready.
  - With out_ready held high, one word per cycle, no bubbles after the first.
  - Last handshake (word OUT_WORDS-1) → DONE.
- DONE: done=1 for one cycle, out_valid=0, then LOAD with counters cleared. err is not cleared.
- in_ready=0 in all states except LOAD. out_valid=0 in all states except DRAIN.

Decomposition:
- Package hir_mem_pkg holds:
  - state enum `state_e` {LOAD, START, RUN, DRAIN, DONE}
  - default DATA_W and ADDR_W localparams
- Sub-module hir_sdp_ram (one write port, one registered read port with read enable, no reset on the array), instantiated twice:
  - in_mem: write from host, read from kernel
  - out_mem: write from kernel, read from drain logic

Test Plan:
- IN_WORDS=OUT_WORDS=4; load 10,11,12,13; kernel reads addresses 0..3 on consecutive cycles → v0_rd_data 10,11,12,13 one cycle after each rd_en; tstart high exactly one cycle, the cycle after the 4th load handshake.
- Kernel writes (addr,data) (3,7),(0,4),(1,5),(2,6) → drain emits 4,5,6,7; done pulses one cycle after the 4th out handshake; next cycle in_ready=1.
- Drain with out_ready pattern 1,0,0,1,1,0,1 → out_data holds through stalls; exactly 4 handshakes in order 4,5,6,7; no duplicate or dropped word.
- Write addr 2 twice (data 9 then 8) plus addrs 0,1 → job ends after 4 strobes; drain yields mem[0],mem[1],8, then mem[3] (previous contents).
- v1_wr_en pulsed during LOAD → err=1 and stays 1; out_mem unchanged. Read with v0_addr=5 while IN_WORDS=4 → err=1.
- rst_n dropped during RUN after 2 writes → all outputs at reset values asynchronously; after release in_ready=1 and a full new job completes correctly.
